// File: rtl/instr_decoder_pkg.sv
// rtl/instr_decoder_pkg.sv - RV32I opcode constants and immediate format encoding
package instr_decoder_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/instr_decoder_imm_gen.sv
// rtl/instr_decoder_imm_gen.sv - sign-extended immediate assembly for each RV32I format
module imm_gen
    import instr_decoder_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // Scatter the encoded immediate bits back into place; instr[31] is always the sign
    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - RV32I decode-stage classifier with field/immediate extraction
module instr_decoder
    import instr_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        is_alu_reg,
    output logic        is_alu_imm,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jalr,
    output logic        is_jal,
    output logic        is_lui,
    output logic        is_auipc,
    output logic        is_system,
    output logic        reg_write,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic        illegal,
    output logic        illegal_seen
);

    logic [6:0] opcode;
    imm_fmt_e   imm_fmt;

    assign opcode = instr[6:0];

    // Full 7-bit compare per class so the low "11" bits are enforced and flags stay mutually exclusive
    always_comb begin
        is_alu_reg = (opcode == OP_REG);
        is_alu_imm = (opcode == OP_IMM);
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        is_branch  = (opcode == OP_BRANCH);
        is_jalr    = (opcode == OP_JALR);
        is_jal     = (opcode == OP_JAL);
        is_lui     = (opcode == OP_LUI);
        is_auipc   = (opcode == OP_AUIPC);
        is_system  = (opcode == OP_SYSTEM);
    end

    // rd==0 is not special here; the register file drops writes to x0
    always_comb begin
        reg_write = is_alu_reg | is_alu_imm | is_load | is_jalr | is_jal | is_lui | is_auipc;
        illegal   = ~(is_alu_reg | is_alu_imm | is_load | is_store | is_branch |
                      is_jalr | is_jal | is_lui | is_auipc | is_system);
    end

    // Fields come from fixed positions whatever the class
    always_comb begin
        rd     = instr[11:7];
        rs1    = instr[19:15];
        rs2    = instr[24:20];
        funct3 = instr[14:12];
        funct7 = instr[31:25];
    end

    // Pick the immediate layout from the decoded class; R-type and illegal give zero
    always_comb begin
        imm_fmt = IMM_NONE;
        if (is_alu_imm || is_load || is_jalr || is_system) begin
            imm_fmt = IMM_I;
        end else if (is_store) begin
            imm_fmt = IMM_S;
        end else if (is_branch) begin
            imm_fmt = IMM_B;
        end else if (is_lui || is_auipc) begin
            imm_fmt = IMM_U;
        end else if (is_jal) begin
            imm_fmt = IMM_J;
        end
    end

    imm_gen u_imm_gen (
        .instr (instr[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    // Sticky record of any illegal opcode since reset; reset takes priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else begin
            illegal_seen <= illegal_seen | illegal;
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - directed vector bench for instr_decoder
module tb_instr_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        is_alu_reg, is_alu_imm, is_load, is_store, is_branch;
    logic        is_jalr, is_jal, is_lui, is_auipc, is_system;
    logic        reg_write;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
    logic        illegal_seen;

    int checks = 0;
    int errors = 0;

    instr_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .is_alu_reg   (is_alu_reg),
        .is_alu_imm   (is_alu_imm),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_branch    (is_branch),
        .is_jalr      (is_jalr),
        .is_jal       (is_jal),
        .is_lui       (is_lui),
        .is_auipc     (is_auipc),
        .is_system    (is_system),
        .reg_write    (reg_write),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct3       (funct3),
        .funct7       (funct7),
        .imm          (imm),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags order: alu_reg alu_imm load store branch jalr jal lui auipc system
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [9:0]  flags;
        logic        reg_write;
        logic        illegal;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add",        32'h002081B3, 10'b1000000000, 1'b1, 1'b0, 32'h00000000, 5'd3, 5'd1, 5'd2};
        vecs[1]  = '{"addi",       32'h00508193, 10'b0100000000, 1'b1, 1'b0, 32'h00000005, 5'd3, 5'd1, 5'd5};
        vecs[2]  = '{"lw",         32'h0040A183, 10'b0010000000, 1'b1, 1'b0, 32'h00000004, 5'd3, 5'd1, 5'd4};
        vecs[3]  = '{"sw",         32'h0030A223, 10'b0001000000, 1'b0, 1'b0, 32'h00000004, 5'd4, 5'd1, 5'd3};
        vecs[4]  = '{"beq",        32'h00308163, 10'b0000100000, 1'b0, 1'b0, 32'h00000002, 5'd2, 5'd1, 5'd3};
        vecs[5]  = '{"jalr",       32'h004081E7, 10'b0000010000, 1'b1, 1'b0, 32'h00000004, 5'd3, 5'd1, 5'd4};
        vecs[6]  = '{"jal",        32'h000001EF, 10'b0000001000, 1'b1, 1'b0, 32'h00000000, 5'd3, 5'd0, 5'd0};
        vecs[7]  = '{"lui",        32'h000011B7, 10'b0000000100, 1'b1, 1'b0, 32'h00001000, 5'd3, 5'd0, 5'd0};
        vecs[8]  = '{"auipc",      32'h00001197, 10'b0000000010, 1'b1, 1'b0, 32'h00001000, 5'd3, 5'd0, 5'd0};
        vecs[9]  = '{"addi_neg1",  32'hFFF00093, 10'b0100000000, 1'b1, 1'b0, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd31};
        vecs[10] = '{"ecall",      32'h00000073, 10'b0000000001, 1'b0, 1'b0, 32'h00000000, 5'd0, 5'd0, 5'd0};
        vecs[11] = '{"illegal7f",  32'h0000007F, 10'b0000000000, 1'b0, 1'b1, 32'h00000000, 5'd0, 5'd0, 5'd0};
        vecs[12] = '{"beq_neg",    32'h80000063, 10'b0000100000, 1'b0, 1'b0, 32'hFFFFF000, 5'd0, 5'd0, 5'd0};
        vecs[13] = '{"jal_neg",    32'h8000006F, 10'b0000001000, 1'b1, 1'b0, 32'hFFF00000, 5'd0, 5'd0, 5'd0};
        vecs[14] = '{"sw_neg",     32'hFE000023, 10'b0001000000, 1'b0, 1'b0, 32'hFFFFFFE0, 5'd0, 5'd0, 5'd0};
        vecs[15] = '{"low_bits01", 32'h00000031, 10'b0000000000, 1'b0, 1'b1, 32'h00000000, 5'd0, 5'd0, 5'd0};

        rst_n = 1'b0;
        instr = 32'h00000013;
        tick();
        tick();
        check("reset_illegal_seen", {31'd0, illegal_seen}, 32'd0);

        // Combinational vectors; reset held so the sticky flag does not move
        for (int i = 0; i < 16; i++) begin
            instr = vecs[i].instr;
            #1;
            check({vecs[i].name, "_flags"},
                  {22'd0, is_alu_reg, is_alu_imm, is_load, is_store, is_branch,
                   is_jalr, is_jal, is_lui, is_auipc, is_system}, {22'd0, vecs[i].flags});
            check({vecs[i].name, "_reg_write"}, {31'd0, reg_write}, {31'd0, vecs[i].reg_write});
            check({vecs[i].name, "_illegal"},   {31'd0, illegal},   {31'd0, vecs[i].illegal});
            check({vecs[i].name, "_imm"},       imm,                vecs[i].imm);
            check({vecs[i].name, "_rd"},        {27'd0, rd},        {27'd0, vecs[i].rd});
            check({vecs[i].name, "_rs1"},       {27'd0, rs1},       {27'd0, vecs[i].rs1});
            check({vecs[i].name, "_rs2"},       {27'd0, rs2},       {27'd0, vecs[i].rs2});
            check({vecs[i].name, "_funct3"},    {29'd0, funct3},    {29'd0, vecs[i].instr[14:12]});
            check({vecs[i].name, "_funct7"},    {25'd0, funct7},    {25'd0, vecs[i].instr[31:25]});
            check({vecs[i].name, "_seen_held"}, {31'd0, illegal_seen}, 32'd0);
        end

        // Sticky flag sequences
        instr = 32'h002081B3;
        #1;
        rst_n = 1'b1;
        tick();
        check("seen_legal_stays0", {31'd0, illegal_seen}, 32'd0);

        instr = 32'h0000007F;
        tick();
        check("seen_set", {31'd0, illegal_seen}, 32'd1);

        instr = 32'h00508193;
        tick();
        check("seen_sticky", {31'd0, illegal_seen}, 32'd1);
        tick();
        check("seen_sticky2", {31'd0, illegal_seen}, 32'd1);

        instr = 32'h0000007F;
        rst_n = 1'b0;
        tick();
        check("seen_reset_wins", {31'd0, illegal_seen}, 32'd0);

        rst_n = 1'b1;
        tick();
        check("seen_after_reset", {31'd0, illegal_seen}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- RV32I base-opcode decoder in the CPU decode stage.
- Classifies a 32-bit instruction into one-hot class flags and derives reg_write.
- Extracts register and function fields and produces the sign-extended immediate for the decoded format.
- Flags, fields and immediate are purely combinational with zero latency. The only state is a sticky illegal-opcode flag clocked by clk.

Parameters:
- none

Ports:
- clk  input  1  system clock; used only by the sticky flag
- rst_n  input  1  synchronous active-low reset
- instr  input  32  instruction word
- is_alu_reg  output  1  opcode 0110011 (R-type ALU)
- is_alu_imm  output  1  opcode 0010011 (I-type ALU)
- is_load  output  1  opcode 0000011
- is_store  output  1  opcode 0100011
- is_branch  output  1  opcode 1100011
- is_jalr  output  1  opcode 1100111
- is_jal  output  1  opcode 1101111
- is_lui  output  1  opcode 0110111
- is_auipc  output  1  opcode 0010111
- is_system  output  1  opcode 1110011
- reg_write  output  1  instruction writes rd
- rd  output  5  instr[11:7]
- rs1  output  5  instr[19:15]
- rs2  output  5  instr[24:20]
- funct3  output  3  instr[14:12]
- funct7  output  7  instr[31:25]
- imm  output  32  sign-extended immediate
- illegal  output  1  no opcode matched
- illegal_seen  output  1  registered sticky copy of illegal

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Opcode match:
  - Each class flag compares the full instr[6:0] to its 7-bit opcode.
  - Bits [1:0] must be 11.
  - At most one flag is high.
- reg_write = is_alu_reg | is_alu_imm | is_load | is_jalr | is_jal | is_lui | is_auipc.
  - Low for branch, store and system.
  - Not gated by rd==0; the register file discards x0 writes.
- illegal = 1 when no class flag is high. All flags and reg_write are 0 in that case.
- Field outputs are always driven from fixed bit positions, regardless of class.
- imm selection:
  - I-form (alu_imm, load, jalr, system): sign-extended instr[31:20].
  - S-form: sign-extended {instr[31:25], instr[11:7]}.
  - B-form: sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-form (lui, auipc): {instr[31:12], 12'b0}.
  - J-form: sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - R-type and illegal: 0.
- Combinational paths:
  - No dependence on clk or rst_n.
  - Valid within the same delta after instr changes; benches sample 1 ns after drive.
  - X or Z on opcode bits may propagate; no masking.
- illegal_seen:
  - On posedge clk: if !rst_n, cleared to 0; otherwise illegal_seen <= illegal_seen | illegal.
  - Reset wins over a simultaneous illegal instruction.
  - Reset value 0; all other outputs have no reset.

Decomposition:
- Shared package holds:
  - the 7-bit opcode constants (OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM);
  - an imm-format enum (I, S, B, U, J, NONE).
- One sub-module, imm_gen: takes instr plus format select and produces imm.

Test Plan:
- add x3,x1,x2 (0x002081B3) -> is_alu_reg=1, reg_write=1, rd=3, rs1=1, rs2=2, all other flags 0, illegal=0.
- Per-class sweep:
  - addi 0x00508193 -> is_alu_imm=1, reg_write=1, imm=5.
  - lw 0x0040A183 -> is_load=1, reg_write=1, imm=4.
  - sw 0x0030A223 -> is_store=1, reg_write=0, imm=4.
  - beq 0x00308163 -> is_branch=1, reg_write=0, imm=2.
  - jalr 0x004081E7 -> is_jalr=1, reg_write=1, imm=4.
- Upper-immediate and jump forms:
  - jal 0x000001EF -> is_jal=1, reg_write=1, imm=0.
  - lui 0x000011B7 -> is_lui=1, reg_write=1, imm=0x00001000.
  - auipc 0x00001197 -> is_auipc=1, reg_write=1, imm=0x00001000.
- Sign extension:
  - addi x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF.
  - ecall 0x00000073 -> is_system=1, reg_write=0.
- Illegal opcode: 0x0000007F -> all flags 0, reg_write=0, illegal=1.
  - Next clk edge -> illegal_seen=1.
  - Stays 1 after a legal instr.
- rst_n=0 for one edge while instr is illegal -> illegal_seen=0.
  - With rst_n=1 on the following edge -> illegal_seen=1.
